// File: rtl/multi_pulser_if.sv
// Purpose: bundles the per-channel raw inputs and the pulse/level outputs of multi_pulser.
// Latency: none, wiring only.
// Backpressure: none, outputs are free-running one-cycle strobes and levels.
interface multi_pulser_if #(
    parameter int N = 4
);
    logic [N-1:0] in;
    logic [N-1:0] pulse;
    logic [N-1:0] level;

    modport master (output in, input pulse, input level);
    modport slave  (input in, output pulse, output level);
endinterface

// File: rtl/multi_pulser.sv
// Purpose: per-channel synchroniser, debouncer, edge-to-pulse converter with optional auto-repeat.
// Latency: level changes SYNC_STAGES+DEBOUNCE-1 edges after a new stable input is first sampled; pulse one edge later.
// Backpressure: none, pulses are one-cycle strobes that are never held or queued.
module multi_pulser #(
    parameter int N             = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int DEBOUNCE      = 4,
    parameter int EDGE_MODE     = 0,
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_PERIOD = 0
) (
    input logic           clk,
    input logic           rst,
    multi_pulser_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
    localparam bit REP_EN = (REPEAT_PERIOD > 0) && (EDGE_MODE == 0);

    logic [N-1:0] pulse_r;
    logic [N-1:0] level_r;

    assign bus.pulse = pulse_r;
    assign bus.level = level_r;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        logic                   sync_val;
        logic [DW-1:0]          db_cnt;
        logic [DW-1:0]          cnt_nxt;
        logic                   lvl;
        logic                   lvl_d;
        logic                   lvl_nxt;
        logic                   rise;
        logic                   fall;
        logic                   edge_hit;
        logic                   rep_hit;
        logic                   pls;

        assign sync_val = sync[SYNC_STAGES-1];

        // Synchroniser chain: the raw input is used nowhere else
        always_ff @(posedge clk) begin
            if (!rst) begin
                sync <= '0;
            end else begin
                sync <= {sync[SYNC_STAGES-2:0], bus.in[i]};
            end
        end

        // Debounce: count cycles of disagreement, flip the level on the DEBOUNCE-th one
        always_comb begin
            lvl_nxt = lvl;
            cnt_nxt = '0;
            if (sync_val != lvl) begin
                if (db_cnt == DB_LAST) begin
                    lvl_nxt = ~lvl;
                end else begin
                    cnt_nxt = db_cnt + 1'b1;
                end
            end
        end

        // Debounce state plus a delayed copy of the level for edge detection
        always_ff @(posedge clk) begin
            if (!rst) begin
                db_cnt <= '0;
                lvl    <= 1'b0;
                lvl_d  <= 1'b0;
            end else begin
                db_cnt <= cnt_nxt;
                lvl    <= lvl_nxt;
                lvl_d  <= lvl;
            end
        end

        // Edge selection on the debounced level
        always_comb begin
            rise     = lvl & ~lvl_d;
            fall     = ~lvl & lvl_d;
            edge_hit = 1'b0;
            case (EDGE_MODE)
                0:       edge_hit = rise;
                1:       edge_hit = fall;
                default: edge_hit = rise | fall;
            endcase
        end

        if (REP_EN) begin : g_rep
            localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
            localparam int RW   = $clog2(RMAX + 1);
            localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
            localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

            logic [RW-1:0] rcnt;
            logic          ractive;
            logic          rperiodic;
            logic          rfire;

            // Fire only while the level is staying high, so nothing escapes on the falling edge
            assign rfire   = ractive && lvl_nxt && (rcnt == (rperiodic ? PER_LAST : DLY_LAST));
            assign rep_hit = rfire;

            // Repeat timer: armed by the initial rising pulse, first gap REPEAT_DELAY then REPEAT_PERIOD
            always_ff @(posedge clk) begin
                if (!rst || !lvl_nxt) begin
                    rcnt      <= '0;
                    ractive   <= 1'b0;
                    rperiodic <= 1'b0;
                end else if (rise) begin
                    rcnt      <= '0;
                    ractive   <= 1'b1;
                    rperiodic <= 1'b0;
                end else if (ractive) begin
                    if (rfire) begin
                        rcnt      <= '0;
                        rperiodic <= 1'b1;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
            end
        end else begin : g_norep
            assign rep_hit = 1'b0;
        end

        // Registered output strobe
        always_ff @(posedge clk) begin
            if (!rst) begin
                pls <= 1'b0;
            end else begin
                pls <= edge_hit | rep_hit;
            end
        end

        assign pulse_r[i] = pls;
        assign level_r[i] = lvl;
    end
endmodule

// File: tb/tb_multi_pulser.sv
// Purpose: directed stimulus with a cycle-stamped expected-pulse scoreboard for three edge modes.
// Latency: expected pulses are stamped at (first sampling edge + 6) for the default parameters.
// Backpressure: not applicable, outputs are observed every cycle.
module tb_multi_pulser;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din;
    int         cyc = 0;
    int         compared = 0;
    int         mismatched = 0;

    typedef struct {
        int         d;
        int         c;
        logic [3:0] m;
    } exp_t;
    exp_t q[$];

    multi_pulser_if #(.N(4)) if0 ();
    multi_pulser_if #(.N(4)) if1 ();
    multi_pulser_if #(.N(4)) if2 ();

    assign if0.in = din;
    assign if1.in = din;
    assign if2.in = din;

    multi_pulser #(.N(4), .SYNC_STAGES(2), .DEBOUNCE(4), .EDGE_MODE(0),
                   .REPEAT_DELAY(20), .REPEAT_PERIOD(8))
        dut0 (.clk(clk), .rst(rst), .bus(if0));
    multi_pulser #(.N(4), .SYNC_STAGES(2), .DEBOUNCE(4), .EDGE_MODE(1),
                   .REPEAT_DELAY(20), .REPEAT_PERIOD(8))
        dut1 (.clk(clk), .rst(rst), .bus(if1));
    multi_pulser #(.N(4), .SYNC_STAGES(2), .DEBOUNCE(4), .EDGE_MODE(2),
                   .REPEAT_DELAY(20), .REPEAT_PERIOD(8))
        dut2 (.clk(clk), .rst(rst), .bus(if2));

    logic [3:0] pv [3];
    assign pv[0] = if0.pulse;
    assign pv[1] = if1.pulse;
    assign pv[2] = if2.pulse;

    always #5 clk = ~clk;

    // Edge counter: after posedge number n, cyc reads n
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int d, input int c, input logic [3:0] m);
        exp_t e;
        e.d = d;
        e.c = c;
        e.m = m;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s at cyc %0d: got %b, expected %b", nm, cyc, act, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Rising input: edge-0 and both-edge instances pulse 6 edges after the first sampling edge
    task automatic press(input logic [3:0] m, output int k);
        k   = cyc + 1;
        din = din | m;
        push(0, k + 6, m);
        push(2, k + 6, m);
    endtask

    // Falling input: falling and both-edge instances pulse 6 edges after the first sampling edge
    task automatic release_in(input logic [3:0] m, output int k);
        k   = cyc + 1;
        din = din & ~m;
        push(1, k + 6, m);
        push(2, k + 6, m);
    endtask

    // Monitor: each cycle, gather expectations stamped for now and compare against any observed pulse
    always @(negedge clk) begin
        logic [3:0] em;
        for (int d = 0; d < 3; d++) begin
            em = 4'b0;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].d == d && q[i].c == cyc) begin
                    em = em | q[i].m;
                    q.delete(i);
                end
            end
            if (pv[d] !== 4'b0 || em != 4'b0) begin
                compared++;
                if (pv[d] !== em) begin
                    mismatched++;
                    $display("FAIL pulse dut%0d at cyc %0d: got %b, expected %b", d, cyc, pv[d], em);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k2, kn;
        rst = 1'b0;
        din = 4'hF;

        // Reset held three edges with all inputs high: outputs stay zero
        repeat (3) begin
            @(negedge clk);
            chk("rst level0", if0.level, 4'h0);
            chk("rst pulse0", if0.pulse, 4'h0);
            chk("rst level1", if1.level, 4'h0);
            chk("rst level2", if2.level, 4'h0);
        end
        rst = 1'b1;
        k = cyc + 1;
        push(0, k + 6, 4'hF);
        push(2, k + 6, 4'hF);
        wait_until(k + 4);
        chk("post-rst level before", if0.level, 4'h0);
        wait_until(k + 5);
        chk("post-rst level0 after", if0.level, 4'hF);
        chk("post-rst level1 after", if1.level, 4'hF);
        chk("post-rst level2 after", if2.level, 4'hF);
        wait_until(k + 10);
        release_in(4'hF, k2);
        idle(14);
        chk("released level", if0.level, 4'h0);

        // Three-cycle glitch on channel 0 is rejected
        din = 4'b0001;
        idle(3);
        din = 4'b0000;
        idle(10);
        chk("glitch3 level0", if0.level, 4'h0);
        chk("glitch3 level1", if1.level, 4'h0);
        chk("glitch3 level2", if2.level, 4'h0);

        // Four-cycle glitch is accepted: one rising and one falling event
        press(4'b0001, k);
        idle(4);
        release_in(4'b0001, k2);
        idle(14);

        // Channels 1 and 2 together, held 10 cycles
        press(4'b0110, k);
        idle(10);
        release_in(4'b0110, k2);
        idle(14);

        // Channel 3 held 60 cycles: initial pulse then repeats at +20, +28, +36, +44, +52
        press(4'b1000, k);
        push(0, k + 26, 4'b1000);
        push(0, k + 34, 4'b1000);
        push(0, k + 42, 4'b1000);
        push(0, k + 50, 4'b1000);
        push(0, k + 58, 4'b1000);
        idle(60);
        release_in(4'b1000, k2);
        idle(14);

        // Reset mid-repeat with channel 3 still held: abort, then restart as a fresh press
        press(4'b1000, k);
        push(0, k + 26, 4'b1000);
        wait_until(k + 31);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst pulse0", if0.pulse, 4'h0);
        chk("midrst level0", if0.level, 4'h0);
        chk("midrst pulse1", if1.pulse, 4'h0);
        chk("midrst pulse2", if2.pulse, 4'h0);
        rst = 1'b1;
        kn = cyc + 1;
        push(0, kn + 6, 4'b1000);
        push(2, kn + 6, 4'b1000);
        push(0, kn + 26, 4'b1000);
        push(0, kn + 34, 4'b1000);
        wait_until(kn + 30);
        release_in(4'b1000, k2);
        idle(14);
        chk("final level", if0.level, 4'h0);

        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard drain: %0d expected pulses never seen", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/multi_pulser.md
MULTI_PULSER -- requirements
Module: multi_pulser

Interface
REQ-001 Parameter N, default 4: number of independent input channels, 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel, >=2.
REQ-003 Parameter DEBOUNCE, default 4: consecutive cycles a changed synchronised input must hold before acceptance, >=1.
REQ-004 Parameter EDGE_MODE, default 0: 0 = rising, 1 = falling, 2 = both edges of the debounced level generate a pulse.
REQ-005 Parameter REPEAT_DELAY, default 20: cycles from the initial rising pulse to the first auto-repeat pulse, >=1.
REQ-006 Parameter REPEAT_PERIOD, default 0: cycles between subsequent auto-repeat pulses; 0 disables auto-repeat.
REQ-007 clk  input  1  sole clock; all state updates on its rising edge.
REQ-008 rst  input  1  reset, synchronous and active-low (rst=0 resets on the next rising clk edge).
REQ-009 in  input  N  asynchronous raw inputs, one per channel (buttons/switches).
REQ-010 pulse  output  N  registered one-cycle pulse per channel.
REQ-011 level  output  N  registered debounced level per channel.

Function
REQ-012 Each channel SHALL be fully independent, with no shared counters or arbitration; simultaneous events on several channels produce simultaneous pulses.
REQ-013 in[i] SHALL pass through a SYNC_STAGES-deep flop chain before any other use.
REQ-014 A per-channel debounce counter, width clog2(DEBOUNCE+1), SHALL increment on every cycle the synchronised value differs from level[i].
REQ-015 The counter SHALL clear on any cycle where the synchronised value equals level[i]; a glitch shorter than DEBOUNCE cycles never changes level[i].
REQ-016 When the synchronised value differs and the counter equals DEBOUNCE-1, level[i] SHALL toggle on that edge and the counter SHALL clear.
REQ-017 Latency: if edge k is the first edge sampling a new stable in[i], level[i] SHALL change at edge k+SYNC_STAGES+DEBOUNCE-1; pulse[i] SHALL be high for exactly the cycle after edge k+SYNC_STAGES+DEBOUNCE.
REQ-018 pulse[i] SHALL assert for a level[i] transition only if that transition matches EDGE_MODE (0: 0->1, 1: 1->0, 2: either).
REQ-019 pulse[i] SHALL never be high for two consecutive cycles from edge detection alone; a held input yields one pulse.
REQ-020 Auto-repeat (REPEAT_PERIOD>0 and EDGE_MODE=0 only): a per-channel repeat counter SHALL start at the initial rising pulse.
REQ-021 The first repeat pulse SHALL occur REPEAT_DELAY cycles after the initial pulse; further pulses occur every REPEAT_PERIOD cycles while level[i]=1.
REQ-022 The repeat counter SHALL clear, with no further repeat pulses, in the cycle level[i] falls.
REQ-023 Repeat counter width SHALL be clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1); it SHALL never wrap while level[i]=1.
REQ-024 When REPEAT_PERIOD=0, or EDGE_MODE is not 0, no repeat logic SHALL be generated and behaviour SHALL equal edge-only mode.

Reset
REQ-025 While rst=0 at a clock edge, all synchroniser flops, debounce counters, repeat counters, level and pulse SHALL load 0.
REQ-026 A channel held high through reset SHALL be treated as a new rising edge after release (pulse per REQ-017 with k = first edge with rst=1).
REQ-027 Reset asserted mid-debounce or mid-repeat SHALL abort it; no pulse SHALL be emitted in the cycle after any edge where rst=0.

Verification (N=4, SYNC_STAGES=2, DEBOUNCE=4, EDGE_MODE=0, REPEAT_DELAY=20, REPEAT_PERIOD=8 unless stated)
REQ-028 Hold rst=0 for 3 cycles with in=4'hF -> level=0 and pulse=0 throughout; release -> pulse=4'hF for exactly one cycle after edge k+6, then level=4'hF.
REQ-029 in[0] high for 3 cycles, then low -> level[0] and pulse[0] stay 0; a 4-cycle glitch -> exactly one pulse.
REQ-030 in[1] and in[2] rise on the same cycle and are held 10 cycles -> pulse=4'b0110 in a single cycle, one pulse each; EDGE_MODE=2 variant -> second pulse after release.
REQ-031 Hold in[3] high for 60 cycles -> pulses at t0, t0+20, t0+28, t0+36, t0+44, t0+52 (6 total); none after level[3] falls.
REQ-032 Hold in[3] until after t0+24, assert rst=0 for one cycle, keep in[3]=1 -> all outputs 0 the cycle after reset; new initial pulse 6 cycles after release; repeat restarts from it.
REQ-033 EDGE_MODE=1: press and release in[0] -> exactly one pulse, 6 cycles after the release edge, none on press.
